// File: rtl/load_store_unit_if.sv
// Request/response handshake plus the word-wide data_memory port of the load/store unit.
// The unit uses the slave modport; the CPU side / memory model uses master.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_a, mem_we, mem_wd
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_a, mem_we, mem_wd
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle byte/half/word load/store unit in front of a word-only data memory.
// Sub-word stores are read-modify-write; loads are lane-extracted and sign/zero extended.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 8192
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        req_err;
  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  always_comb begin
    req_err = 1'b0;
    if (bus.req_size == 2'd3) req_err = 1'b1;
    if (bus.req_size == 2'd1 && bus.req_addr[0]) req_err = 1'b1;
    if (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (bus.req_addr > 32'(MEM_BYTES - 1)) req_err = 1'b1;
  end

  // Lane arithmetic works on the word captured from memory during RD.
  always_comb begin
    shamt   = {lane_q, 3'b000};
    shifted = bus.mem_rd >> shamt;
    case (size_q)
      2'd0:    load_val = uns_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
      2'd1:    load_val = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = bus.mem_rd;
    endcase
    lane_mask = (size_q == 2'd0) ? (32'h0000_00FF << shamt) : (32'h0000_FFFF << shamt);
    merged    = (bus.mem_rd & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
  end

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    size_d       = size_q;
    we_d         = we_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    mem_a_d      = mem_a_q;
    mem_we_d     = 1'b0;
    mem_wd_d     = 32'h0;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        mem_a_d = 32'h0;
        if (bus.req_valid) begin
          lane_d  = bus.req_addr[1:0];
          size_d  = bus.req_size;
          we_d    = bus.req_we;
          uns_d   = bus.req_unsigned;
          wdata_d = bus.req_wdata;
          mem_a_d = {bus.req_addr[31:2], 2'b00};
          if (req_err) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else if (bus.req_we && bus.req_size == 2'd2) begin
            state_d  = S_WR;
            mem_we_d = 1'b1;
            mem_wd_d = bus.req_wdata;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (we_q) begin
          state_d  = S_WR;
          mem_we_d = 1'b1;
          mem_wd_d = merged;
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = load_val;
        end
      end
      S_WR: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
      end
      default: begin
        if (bus.resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 32'h0;
          mem_a_d      = 32'h0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lane_q       <= 2'b00;
      size_q       <= 2'b00;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      wdata_q      <= 32'h0;
      mem_a_q      <= 32'h0;
      mem_we_q     <= 1'b0;
      mem_wd_q     <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      we_q         <= we_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      mem_a_q      <= mem_a_d;
      mem_we_q     <= mem_we_d;
      mem_wd_q     <= mem_wd_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Gating with rst_n lets a reset arriving during WR cancel the pending write.
  assign bus.mem_we     = mem_we_q && rst_n;
  assign bus.mem_wd     = mem_wd_q;
  assign bus.mem_a      = mem_a_q;
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word-wide data memory.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();
  load_store_unit #(.MEM_BYTES(8192)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] mem [0:2047];
  assign bus.mem_rd = mem[bus.mem_a[12:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_a[12:2]] <= bus.mem_wd;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we_cycles;
  } exp_t;
  exp_t sb[$];

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic do_req(input string name, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                        input int exp_we, input int hold);
    exp_t e;
    int lat, wec;
    logic got;
    logic [31:0] held;
    e = '{rdata: exp_rdata, err: exp_err, lat: exp_lat, we_cycles: exp_we};
    sb.push_back(e);
    @(negedge clk);
    chk({name, " req_ready"}, {31'h0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    wec = bus.mem_we ? 1 : 0;
    got = bus.resp_valid;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.mem_we) wec++;
      got = bus.resp_valid;
    end
    e = sb.pop_front();
    chk({name, " resp_valid"}, {31'h0, got}, 32'd1);
    chk({name, " latency"}, lat, e.lat);
    chk({name, " rdata"}, bus.resp_rdata, e.rdata);
    chk({name, " err"}, {31'h0, bus.resp_err}, {31'h0, e.err});
    chk({name, " mem_we cycles"}, wec, e.we_cycles);
    held = bus.resp_rdata;
    // Stalled response: a competing request must be ignored while in RESP.
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_addr = 32'h40;
      bus.req_wdata = 32'h5555_5555;
      @(negedge clk);
      chk({name, " stall valid/ready/rdata"},
          {bus.resp_valid, bus.req_ready, bus.mem_we, 29'h0} ^ (bus.resp_rdata ^ held),
          {1'b1, 1'b0, 1'b0, 29'h0});
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk({name, " release -> idle"}, {30'h0, bus.resp_valid, bus.req_ready}, 32'd1);
    $display("[TB] %s addr=0x%08h we=%0d size=%0d rdata=0x%08h err=%0d lat=%0d",
             name, addr, we, size, held, e.err, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", {31'h0, bus.req_ready}, 32'd1);
    chk("reset resp_valid/err/we", {29'h0, bus.resp_valid, bus.resp_err, bus.mem_we}, 32'd0);
    chk("reset resp_rdata", bus.resp_rdata, 32'd0);
    chk("reset mem_a", bus.mem_a, 32'd0);
    chk("reset mem_wd", bus.mem_wd, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic test_loads();
    do_req("lb 0x13",  1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0, 0);
    do_req("lbu 0x13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h0000_0080, 1'b0, 2, 0, 0);
    do_req("lh 0x12",  1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'hFFFF_80FF, 1'b0, 2, 0, 0);
    do_req("lhu 0x10", 1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 32'h0000_7F01, 1'b0, 2, 0, 0);
    do_req("lw 0x10",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h80FF_7F01, 1'b0, 2, 0, 0);
    do_req("lb 0x11",  1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 32'h0000_007F, 1'b0, 2, 0, 0);
    do_req("lbu 0x1FFF", 1'b0, 2'd0, 1'b1, 32'h1FFF, 32'h0, 32'h0000_007A, 1'b0, 2, 0, 0);
  endtask

  task automatic test_stores();
    do_req("sb 0x21", 1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFF_FFAB, 32'h0, 1'b0, 3, 1, 0);
    chk("sb 0x21 memory", mem[8], 32'h1122_AB44);
    do_req("sh 0x22", 1'b1, 2'd1, 1'b0, 32'h22, 32'h1234_BEEF, 32'h0, 1'b0, 3, 1, 0);
    chk("sh 0x22 memory", mem[8], 32'hBEEF_AB44);
    do_req("sw 0x40", 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 1, 0);
    chk("sw 0x40 memory", mem[16], 32'hCAFE_F00D);
    chk("sw 0x40 neighbour", mem[17], 32'h0);
  endtask

  task automatic test_errors();
    do_req("lw 0x06",   1'b0, 2'd2, 1'b0, 32'h06,   32'h0,  32'h0, 1'b1, 1, 0, 0);
    do_req("sh 0x05",   1'b1, 2'd1, 1'b0, 32'h05,   32'hFF, 32'h0, 1'b1, 1, 0, 0);
    do_req("size3",     1'b0, 2'd3, 1'b0, 32'h10,   32'h0,  32'h0, 1'b1, 1, 0, 0);
    do_req("sw 0x2000", 1'b1, 2'd2, 1'b0, 32'h2000, 32'h77, 32'h0, 1'b1, 1, 0, 0);
    chk("error stores left memory", mem[1], 32'h0);
    chk("error sw 0x2000 no alias", mem[0], 32'h0);
  endtask

  task automatic test_back_pressure();
    do_req("lw 0x10 stalled", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h80FF_7F01, 1'b0, 2, 0, 5);
    chk("ignored store not written", mem[16], 32'hCAFE_F00D);
  endtask

  task automatic test_reset_mid_store();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h30; bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mid-store in WR", {31'h0, bus.mem_we}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid-store memory unchanged", mem[12], 32'h1234_5678);
    chk("mid-store outputs reset", {28'h0, bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_we}, 32'h8);
    chk("mid-store mem_a/wd/rdata", bus.mem_a | bus.mem_wd | bus.resp_rdata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid-store no response", {31'h0, bus.resp_valid}, 32'd0);
    end
    $display("[TB] reset during sw 0x30: memory=0x%08h", mem[12]);
    do_req("lw 0x30 after reset", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'h1234_5678, 1'b0, 2, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    mem[4]    = 32'h80FF_7F01;
    mem[8]    = 32'h1122_3344;
    mem[12]   = 32'h1234_5678;
    mem[2047] = 32'h7A00_0000;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b0;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_back_pressure();
    test_reset_mid_store();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
